ola_trigger_sequencer: RTL and testbench

OLA_TRIGGER_SEQUENCER -- requirements
Module: ola_trigger_sequencer

---
 rtl/ola_trigger_sequencer.sv | 148 ++++++++++++++
 tb/tb_ola_trigger_sequencer.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ola_trigger_sequencer.sv
// Multi-state trigger sequencer for a logic analyzer sample stream.
// Each state matches value/edge masks, counts occurrences, then branches and/or fires a delayed trigger.
module ola_trigger_sequencer #(
    parameter int SAMPLE_WIDTH = 8,
    parameter int STATE_WIDTH  = 2,
    parameter int COUNT_WIDTH  = 8
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    cfg_we,
    input  logic [STATE_WIDTH-1:0]  cfg_state,
    input  logic [2:0]              cfg_field,
    input  logic [SAMPLE_WIDTH-1:0] cfg_data,
    input  logic                    arm,
    input  logic                    in_valid,
    input  logic [SAMPLE_WIDTH-1:0] in_sample,
    input  logic [SAMPLE_WIDTH-1:0] in_falling,
    input  logic [SAMPLE_WIDTH-1:0] in_rising,
    output logic                    out_valid,
    output logic [SAMPLE_WIDTH-1:0] out_sample,
    output logic                    out_trigger,
    output logic                    armed,
    output logic                    triggered,
    output logic [STATE_WIDTH-1:0]  cur_state
);

    localparam int STATE_COUNT = 2 ** STATE_WIDTH;

    typedef enum logic [1:0] {
        MODE_IDLE,
        MODE_RUN,
        MODE_DELAY
    } mode_t;

    logic [SAMPLE_WIDTH-1:0] vmask_q [STATE_COUNT];
    logic [SAMPLE_WIDTH-1:0] value_q [STATE_COUNT];
    logic [SAMPLE_WIDTH-1:0] rmask_q [STATE_COUNT];
    logic [SAMPLE_WIDTH-1:0] fmask_q [STATE_COUNT];
    logic [COUNT_WIDTH-1:0]  count_q [STATE_COUNT];
    logic                    act_trig_q [STATE_COUNT];
    logic                    act_goto_q [STATE_COUNT];
    logic [STATE_WIDTH-1:0]  act_next_q [STATE_COUNT];
    logic [COUNT_WIDTH-1:0]  delay_q;

    mode_t                   mode;
    logic [COUNT_WIDTH-1:0]  occ_cnt;
    logic [COUNT_WIDTH-1:0]  delay_cnt;
    logic                    match;

    // Configuration is frozen while the engine runs so a capture sees a stable program.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < STATE_COUNT; i++) begin
                vmask_q[i]    <= '0;
                value_q[i]    <= '0;
                rmask_q[i]    <= '0;
                fmask_q[i]    <= '0;
                count_q[i]    <= '0;
                act_trig_q[i] <= 1'b0;
                act_goto_q[i] <= 1'b0;
                act_next_q[i] <= '0;
            end
            delay_q <= '0;
        end else if (cfg_we && !armed) begin
            case (cfg_field)
                3'd0: vmask_q[cfg_state] <= cfg_data;
                3'd1: value_q[cfg_state] <= cfg_data;
                3'd2: rmask_q[cfg_state] <= cfg_data;
                3'd3: fmask_q[cfg_state] <= cfg_data;
                3'd4: count_q[cfg_state] <= cfg_data[COUNT_WIDTH-1:0];
                3'd5: begin
                    act_trig_q[cfg_state] <= cfg_data[0];
                    act_goto_q[cfg_state] <= cfg_data[1];
                    act_next_q[cfg_state] <= cfg_data[2 +: STATE_WIDTH];
                end
                3'd6: delay_q <= cfg_data[COUNT_WIDTH-1:0];
                default: ;
            endcase
        end
    end

    always_comb begin
        match = (((in_sample ^ value_q[cur_state]) & vmask_q[cur_state]) == '0)
             && ((in_rising & rmask_q[cur_state]) == rmask_q[cur_state])
             && ((in_falling & fmask_q[cur_state]) == fmask_q[cur_state]);
    end

    // Sequencer engine: arm restarts everything; only valid samples advance
    // the occurrence and delay counters, so input gaps stretch the delay.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            mode        <= MODE_IDLE;
            armed       <= 1'b0;
            triggered   <= 1'b0;
            cur_state   <= '0;
            occ_cnt     <= '0;
            delay_cnt   <= '0;
            out_valid   <= 1'b0;
            out_sample  <= '0;
            out_trigger <= 1'b0;
        end else begin
            out_valid   <= in_valid;
            out_sample  <= in_sample;
            out_trigger <= 1'b0;
            if (arm) begin
                mode      <= MODE_RUN;
                armed     <= 1'b1;
                triggered <= 1'b0;
                cur_state <= '0;
                occ_cnt   <= '0;
                delay_cnt <= '0;
            end else if (armed && in_valid) begin
                if (mode == MODE_DELAY) begin
                    if (delay_cnt == COUNT_WIDTH'(1)) begin
                        out_trigger <= 1'b1;
                        triggered   <= 1'b1;
                        armed       <= 1'b0;
                        mode        <= MODE_IDLE;
                    end else begin
                        delay_cnt <= delay_cnt - COUNT_WIDTH'(1);
                    end
                end
                if (match) begin
                    if (occ_cnt == count_q[cur_state]) begin
                        occ_cnt <= '0;
                        if (act_goto_q[cur_state]) begin
                            cur_state <= act_next_q[cur_state];
                        end
                        if (act_trig_q[cur_state] && mode == MODE_RUN && !triggered) begin
                            if (delay_q == '0) begin
                                out_trigger <= 1'b1;
                                triggered   <= 1'b1;
                                armed       <= 1'b0;
                                mode        <= MODE_IDLE;
                            end else begin
                                mode      <= MODE_DELAY;
                                delay_cnt <= delay_q;
                            end
                        end
                    end else begin
                        occ_cnt <= occ_cnt + COUNT_WIDTH'(1);
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_ola_trigger_sequencer.sv
// Directed self-checking bench for ola_trigger_sequencer with hand-computed expectations.
module tb_ola_trigger_sequencer;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       cfg_we = 1'b0;
    logic [1:0] cfg_state = '0;
    logic [2:0] cfg_field = '0;
    logic [7:0] cfg_data = '0;
    logic       arm = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] in_sample = '0;
    logic [7:0] in_falling = '0;
    logic [7:0] in_rising = '0;
    logic       out_valid;
    logic [7:0] out_sample;
    logic       out_trigger;
    logic       armed;
    logic       triggered;
    logic [1:0] cur_state;

    int checkCount = 0;
    int errorCount = 0;

    ola_trigger_sequencer #(
        .SAMPLE_WIDTH(8),
        .STATE_WIDTH(2),
        .COUNT_WIDTH(8)
    ) dut (
        .clock(clock),
        .reset(reset),
        .cfg_we(cfg_we),
        .cfg_state(cfg_state),
        .cfg_field(cfg_field),
        .cfg_data(cfg_data),
        .arm(arm),
        .in_valid(in_valid),
        .in_sample(in_sample),
        .in_falling(in_falling),
        .in_rising(in_rising),
        .out_valid(out_valid),
        .out_sample(out_sample),
        .out_trigger(out_trigger),
        .armed(armed),
        .triggered(triggered),
        .cur_state(cur_state)
    );

    always #5 clock = ~clock;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic doReset();
        reset = 1'b1;
        step();
        reset = 1'b0;
        step();
    endtask

    task automatic cfgWrite(input logic [1:0] st, input logic [2:0] fld, input logic [7:0] data);
        in_valid  = 1'b0;
        cfg_we    = 1'b1;
        cfg_state = st;
        cfg_field = fld;
        cfg_data  = data;
        step();
        cfg_we = 1'b0;
    endtask

    task automatic pulseArm(input logic valid, input logic [7:0] sample);
        arm       = 1'b1;
        in_valid  = valid;
        in_sample = sample;
        step();
        arm      = 1'b0;
        in_valid = 1'b0;
    endtask

    task automatic applyStimulus(input logic valid, input logic [7:0] sample,
                                 input logic [7:0] rising, input logic [7:0] falling);
        in_valid   = valid;
        in_sample  = sample;
        in_rising  = rising;
        in_falling = falling;
        step();
        in_valid   = 1'b0;
        in_rising  = '0;
        in_falling = '0;
    endtask

    initial begin
        // Reset state
        doReset();
        checkOutput("rst_armed", armed, 0);
        checkOutput("rst_triggered", triggered, 0);
        checkOutput("rst_out_valid", out_valid, 0);
        checkOutput("rst_out_trigger", out_trigger, 0);
        checkOutput("rst_cur_state", cur_state, 0);

        // Value match on state 0
        cfgWrite(0, 3'd0, 8'hFF);
        cfgWrite(0, 3'd1, 8'h5A);
        cfgWrite(0, 3'd5, 8'h01);
        pulseArm(0, 8'h00);
        checkOutput("v_armed", armed, 1);
        applyStimulus(1, 8'h00, 0, 0);
        checkOutput("v_no_trig", out_trigger, 0);
        checkOutput("v_out_sample0", out_sample, 8'h00);
        applyStimulus(1, 8'h5A, 0, 0);
        checkOutput("v_trig", out_trigger, 1);
        checkOutput("v_trig_sample", out_sample, 8'h5A);
        checkOutput("v_triggered", triggered, 1);
        checkOutput("v_disarmed", armed, 0);
        applyStimulus(0, 8'h5A, 0, 0);
        checkOutput("v_trig_pulse", out_trigger, 0);
        checkOutput("v_out_valid_low", out_valid, 0);

        // Re-arm: the arm-cycle sample is not evaluated, then retrigger
        pulseArm(1, 8'h5A);
        checkOutput("ra_triggered_clr", triggered, 0);
        checkOutput("ra_armed", armed, 1);
        checkOutput("ra_arm_sample_ignored", out_trigger, 0);
        checkOutput("ra_out_valid", out_valid, 1);
        applyStimulus(1, 8'h5A, 0, 0);
        checkOutput("ra_retrig", out_trigger, 1);

        // Rising mask with count 2, invalid cycles not counted
        doReset();
        cfgWrite(0, 3'd2, 8'h01);
        cfgWrite(0, 3'd4, 8'h02);
        cfgWrite(0, 3'd5, 8'h01);
        pulseArm(0, 8'h00);
        applyStimulus(1, 8'h00, 8'h01, 0);
        checkOutput("r_m1", out_trigger, 0);
        applyStimulus(0, 8'h00, 8'h01, 0);
        checkOutput("r_invalid", out_trigger, 0);
        applyStimulus(1, 8'h00, 8'h02, 0);
        checkOutput("r_nomatch", out_trigger, 0);
        applyStimulus(1, 8'h00, 8'h01, 0);
        checkOutput("r_m2", out_trigger, 0);
        applyStimulus(1, 8'h00, 8'h03, 0);
        checkOutput("r_m3_trig", out_trigger, 1);

        // Falling mask
        doReset();
        cfgWrite(0, 3'd3, 8'h80);
        cfgWrite(0, 3'd5, 8'h01);
        pulseArm(0, 8'h00);
        applyStimulus(1, 8'h00, 8'h80, 8'h00);
        checkOutput("f_nomatch", out_trigger, 0);
        applyStimulus(1, 8'h00, 8'h00, 8'h80);
        checkOutput("f_trig", out_trigger, 1);

        // Two-state sequence with goto, plus arm-while-armed restart
        doReset();
        cfgWrite(0, 3'd0, 8'hFF);
        cfgWrite(0, 3'd1, 8'h01);
        cfgWrite(0, 3'd5, 8'h06);
        cfgWrite(1, 3'd0, 8'hFF);
        cfgWrite(1, 3'd1, 8'h02);
        cfgWrite(1, 3'd5, 8'h01);
        pulseArm(0, 8'h00);
        applyStimulus(1, 8'h02, 0, 0);
        checkOutput("s_first02", out_trigger, 0);
        checkOutput("s_state0", cur_state, 0);
        applyStimulus(1, 8'h01, 0, 0);
        checkOutput("s_goto1", cur_state, 1);
        checkOutput("s_goto_notrig", out_trigger, 0);
        applyStimulus(1, 8'h02, 0, 0);
        checkOutput("s_second02_trig", out_trigger, 1);
        pulseArm(0, 8'h00);
        applyStimulus(1, 8'h01, 0, 0);
        checkOutput("s_to1_again", cur_state, 1);
        pulseArm(0, 8'h00);
        checkOutput("s_restart_state", cur_state, 0);
        checkOutput("s_restart_armed", armed, 1);
        applyStimulus(1, 8'h02, 0, 0);
        checkOutput("s_restart_notrig", out_trigger, 0);

        // Delay of 3 valid samples with gaps
        doReset();
        cfgWrite(0, 3'd0, 8'hFF);
        cfgWrite(0, 3'd1, 8'h10);
        cfgWrite(0, 3'd5, 8'h01);
        cfgWrite(0, 3'd6, 8'h03);
        pulseArm(0, 8'h00);
        applyStimulus(1, 8'h10, 0, 0);
        checkOutput("d_k", out_trigger, 0);
        applyStimulus(1, 8'h20, 0, 0);
        checkOutput("d_k1", out_trigger, 0);
        applyStimulus(0, 8'h10, 0, 0);
        checkOutput("d_gap1", out_trigger, 0);
        applyStimulus(1, 8'h21, 0, 0);
        checkOutput("d_k2", out_trigger, 0);
        checkOutput("d_still_armed", armed, 1);
        applyStimulus(0, 8'h10, 0, 0);
        checkOutput("d_gap2", out_trigger, 0);
        applyStimulus(1, 8'h22, 0, 0);
        checkOutput("d_k3_trig", out_trigger, 1);
        checkOutput("d_k3_sample", out_sample, 8'h22);
        checkOutput("d_k3_triggered", triggered, 1);

        // Cfg write while armed ignored; reset during pending delay
        doReset();
        cfgWrite(0, 3'd5, 8'h01);
        cfgWrite(0, 3'd6, 8'h02);
        pulseArm(0, 8'h00);
        cfgWrite(0, 3'd6, 8'h00);
        applyStimulus(1, 8'hA1, 0, 0);
        checkOutput("w_ignored_notrig", out_trigger, 0);
        applyStimulus(1, 8'hA2, 0, 0);
        checkOutput("w_pending", out_trigger, 0);
        checkOutput("w_pending_armed", armed, 1);
        in_valid  = 1'b1;
        in_sample = 8'hA3;
        reset     = 1'b1;
        #1;
        checkOutput("w_rst_trigger", out_trigger, 0);
        checkOutput("w_rst_armed", armed, 0);
        checkOutput("w_rst_out_valid", out_valid, 0);
        checkOutput("w_rst_out_sample", out_sample, 0);
        step();
        reset = 1'b0;
        applyStimulus(1, 8'hA4, 0, 0);
        checkOutput("w_after_rst_notrig", out_trigger, 0);
        checkOutput("w_after_rst_triggered", triggered, 0);

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL timeout: got running, expected finished");
        $fatal(1, "[TB] timeout");
    end

endmodule
